// File: rtl/uart_tx_serializer_if.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer_if
// Read-side link between the TX FIFO and the UART transmit shift engine.
//   fifo_dout  : head byte of the FIFO. It is show-ahead and combinational,
//                and it is only meaningful while fifo_empty is low.
//   fifo_empty : FIFO has nothing to send.
//   fifo_rd_en : one-clk pop strobe issued by the serializer.
// Modports:
//   master : serializer side (consumes dout/empty, drives rd_en)
//   slave  : FIFO side (drives dout/empty, consumes rd_en)
// ---------------------------------------------------------------------------
interface uart_tx_serializer_if;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_rd_en;

  modport master (
    input  fifo_dout,
    input  fifo_empty,
    output fifo_rd_en
  );

  modport slave (
    output fifo_dout,
    output fifo_empty,
    input  fifo_rd_en
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
// Drains the TX FIFO and serializes each byte onto txd in 16550 framing.
// The frame is: a start bit, 5-8 data bits sent LSB first, an optional
// parity bit, then 1, 1.5 or 2 stop bits.
// Ports:
//   clk, rst   : system clock, asynchronous active-high reset
//   baud_tick  : oversample enable, OVERSAMPLE pulses per bit time
//   fifo       : FIFO read port (head byte, empty flag, pop strobe)
//   wls        : word length, 00=5 .. 11=8 data bits
//   stb        : stop bits, 0=1, 1=2 (1.5 when wls=00)
//   pen        : parity enable
//   eps        : even parity select
//   stick_par  : stick parity (the parity bit is ~eps)
//   break_ctl  : holds txd low while it is high
//   txd        : serial line, idle high
//   tx_busy    : a frame is in flight
//   tsr_empty  : shift engine is idle and the FIFO is empty
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  uart_tx_serializer_if.master fifo,
  input  logic [1:0]           wls,
  input  logic                 stb,
  input  logic                 pen,
  input  logic                 eps,
  input  logic                 stick_par,
  input  logic                 break_ctl,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tsr_empty
);

  // The tick counter must hold the longest bit, which is two stop bits.
  localparam int TW = $clog2(2 * OVERSAMPLE);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state;
  logic [TW-1:0]   tick_cnt;
  logic [2:0]      bit_cnt;
  logic [2:0]      bit_last;
  logic [7:0]      shift_reg;
  logic            par_en;
  logic            par_bit;
  logic [TW-1:0]   stop_last;
  logic            line_level;

  logic [7:0]      ld_data;
  logic            ld_par;
  logic [TW-1:0]   ld_stop_last;
  logic            bit_end;
  logic            stop_end;
  logic            pop;

  // Everything that gets captured at load time is derived here.
  // A byte popped in IDLE and a byte popped back-to-back at the end of STOP
  // therefore see exactly the same configuration snapshot. Masking the data
  // to the word length keeps the unsent upper bits out of the parity.
  always_comb begin
    ld_data      = fifo.fifo_dout & (8'hFF >> (2'd3 - wls));
    ld_par       = stick_par ? ~eps : (eps ? ^ld_data : ~^ld_data);
    ld_stop_last = TW'(OVERSAMPLE - 1);
    if (stb) begin
      ld_stop_last = (wls == 2'b00) ? TW'((3 * OVERSAMPLE) / 2 - 1)
                                    : TW'(2 * OVERSAMPLE - 1);
    end
    bit_end  = baud_tick && (tick_cnt == TW'(OVERSAMPLE - 1));
    stop_end = baud_tick && (tick_cnt == stop_last);
    pop      = !rst && !fifo.fifo_empty &&
               ((state == IDLE) || ((state == STOP) && stop_end));
  end

  assign fifo.fifo_rd_en = pop;

  // line_level is the level the FSM wants on the line. txd is that level,
  // overridden by break, registered. Any branch that moves line_level also
  // writes txd with the new value, so the line changes on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      bit_last   <= '0;
      shift_reg  <= '0;
      par_en     <= 1'b0;
      par_bit    <= 1'b0;
      stop_last  <= '0;
      line_level <= 1'b1;
      txd        <= 1'b1;
      tx_busy    <= 1'b0;
      tsr_empty  <= 1'b1;
    end else begin
      tsr_empty <= (state == IDLE) && fifo.fifo_empty;
      txd       <= ~break_ctl & line_level;
      if (pop) begin
        shift_reg  <= ld_data;
        par_en     <= pen;
        par_bit    <= ld_par;
        stop_last  <= ld_stop_last;
        bit_last   <= {1'b0, wls} + 3'd4;
        bit_cnt    <= '0;
        tick_cnt   <= '0;
        tx_busy    <= 1'b1;
        state      <= START;
        line_level <= 1'b0;
        txd        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            tick_cnt <= '0;
          end
          START: begin
            if (bit_end) begin
              tick_cnt   <= '0;
              state      <= DATA;
              line_level <= shift_reg[0];
              txd        <= ~break_ctl & shift_reg[0];
            end else if (baud_tick) begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (bit_end) begin
              tick_cnt <= '0;
              if (bit_cnt == bit_last) begin
                state      <= par_en ? PARITY : STOP;
                line_level <= par_en ? par_bit : 1'b1;
                txd        <= ~break_ctl & (par_en ? par_bit : 1'b1);
              end else begin
                shift_reg  <= shift_reg >> 1;
                bit_cnt    <= bit_cnt + 3'd1;
                line_level <= shift_reg[1];
                txd        <= ~break_ctl & shift_reg[1];
              end
            end else if (baud_tick) begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          PARITY: begin
            if (bit_end) begin
              tick_cnt   <= '0;
              state      <= STOP;
              line_level <= 1'b1;
              txd        <= ~break_ctl;
            end else if (baud_tick) begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          STOP: begin
            // When the FIFO still has data, the pop branch above takes over
            // on this edge. Reaching here at stop_end means the FIFO is empty.
            if (stop_end) begin
              tick_cnt <= '0;
              state    <= IDLE;
              tx_busy  <= 1'b0;
            end else if (baud_tick) begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: begin
            state      <= IDLE;
            line_level <= 1'b1;
            tx_busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer
// Drives uart_tx_serializer from a queue-based FIFO model. The expected
// line is derived per baud tick from a frame description built out of the
// framing rules: start, data LSB first, parity, stop lengths.
// ---------------------------------------------------------------------------
module tb_uart_tx_serializer;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic [1:0] wls;
  logic       stb, pen, eps, stick_par, break_ctl;
  logic       txd, tx_busy, tsr_empty;

  uart_tx_serializer_if fifo_bus ();

  uart_tx_serializer #(.OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .fifo      (fifo_bus),
    .wls       (wls),
    .stb       (stb),
    .pen       (pen),
    .eps       (eps),
    .stick_par (stick_par),
    .break_ctl (break_ctl),
    .txd       (txd),
    .tx_busy   (tx_busy),
    .tsr_empty (tsr_empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // FIFO model and reference frame state
  logic [7:0] fifo_q[$];
  logic       levels[$];
  int         elapsed;
  logic       active;
  int         busy_cnt;
  int         pops;
  logic       hist[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic refreshFifo();
    fifo_bus.fifo_empty = (fifo_q.size() == 0);
    fifo_bus.fifo_dout  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  task automatic pushByte(input logic [7:0] b);
    fifo_q.push_back(b);
    refreshFifo();
  endtask

  // Per-tick line levels of one frame, built from the framing rules.
  task automatic buildFrame(input logic [7:0] b, input logic [1:0] w, input logic s,
                            input logic p, input logic e, input logic sp);
    int n, ones, stop_ticks;
    logic pbit;
    n = int'(w) + 5;
    ones = 0;
    levels.delete();
    for (int t = 0; t < OS; t++) levels.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      if (b[i]) ones++;
      for (int t = 0; t < OS; t++) levels.push_back(b[i]);
    end
    if (p) begin
      if (sp) pbit = !e;
      else if (e) pbit = (ones % 2) == 1;
      else pbit = (ones % 2) == 0;
      for (int t = 0; t < OS; t++) levels.push_back(pbit);
    end
    if (!s) stop_ticks = OS;
    else if (n == 5) stop_ticks = (3 * OS) / 2;
    else stop_ticks = 2 * OS;
    for (int t = 0; t < stop_ticks; t++) levels.push_back(1'b1);
  endtask

  // One clock: check the pop strobe before the edge, advance the model
  // across the edge, then check the registered outputs 1 time unit later.
  task automatic applyStimulus(input logic bt_next);
    logic rd, exp_rd, empty_b, bt, brk, was_active;
    logic [7:0] head;
    logic [1:0] c_wls;
    logic c_stb, c_pen, c_eps, c_sp, exp_txd;
    baud_tick = bt_next;
    @(negedge clk);
    rd = fifo_bus.fifo_rd_en;
    exp_rd = !fifo_bus.fifo_empty &&
             (!active || (baud_tick && elapsed == levels.size() - 1));
    checkOutput("rd_en", rd, exp_rd);
    empty_b = fifo_bus.fifo_empty;
    bt = baud_tick;
    brk = break_ctl;
    head = fifo_bus.fifo_dout;
    c_wls = wls; c_stb = stb; c_pen = pen; c_eps = eps; c_sp = stick_par;
    @(posedge clk);
    #1;
    was_active = active;
    if (active && bt) begin
      elapsed++;
      if (elapsed == levels.size()) active = 1'b0;
    end
    if (rd) begin
      buildFrame(head, c_wls, c_stb, c_pen, c_eps, c_sp);
      elapsed = 0;
      active = 1'b1;
      pops++;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      refreshFifo();
    end
    exp_txd = brk ? 1'b0 : (active ? levels[elapsed] : 1'b1);
    checkOutput("txd", txd, exp_txd);
    checkOutput("tx_busy", tx_busy, active);
    checkOutput("tsr_empty", tsr_empty, !was_active && empty_b);
    if (tx_busy === 1'b1) begin
      busy_cnt++;
      hist.push_back(txd);
    end
  endtask

  // Samples the middle of each bit from the recorded busy-time line history.
  task automatic checkBits(input string tag, input int offset, input logic [15:0] exp, input int nb);
    int idx;
    logic got;
    for (int k = 0; k < nb; k++) begin
      idx = offset + OS * k + OS / 2;
      got = (idx < hist.size()) ? hist[idx] : 1'bx;
      checkOutput(tag, got, exp[k]);
    end
  endtask

  task automatic startScenario(input logic [1:0] w, input logic s, input logic p,
                               input logic e, input logic sp);
    wls = w; stb = s; pen = p; eps = e; stick_par = sp;
    busy_cnt = 0;
    pops = 0;
    hist.delete();
  endtask

  initial begin
    rst = 1'b1;
    baud_tick = 1'b0;
    break_ctl = 1'b0;
    wls = 2'b11; stb = 1'b0; pen = 1'b0; eps = 1'b0; stick_par = 1'b0;
    active = 1'b0;
    elapsed = 0;
    refreshFifo();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_txd", txd, 1'b1);
    checkOutput("rst_busy", tx_busy, 1'b0);
    checkOutput("rst_tsr", tsr_empty, 1'b1);
    checkOutput("rst_rd", fifo_bus.fifo_rd_en, 1'b0);
    rst = 1'b0;

    $display("[TB] 8N1 0x55");
    startScenario(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    pushByte(8'h55);
    for (int i = 0; i < 200; i++) applyStimulus(1'b1);
    checkOutput("8n1_pops", pops, 1);
    checkOutput("8n1_len", busy_cnt, 160);
    checkBits("8n1_bits", 0, 16'h02AA, 10);
    checkOutput("8n1_tsr", tsr_empty, 1'b1);

    $display("[TB] 5E1 0xF3");
    startScenario(2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    pushByte(8'hF3);
    for (int i = 0; i < 150; i++) applyStimulus(1'b1);
    checkOutput("5e1_len", busy_cnt, 128);
    checkBits("5e1_bits", 0, 16'h00E6, 8);

    $display("[TB] 5N1.5");
    startScenario(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    pushByte(8'h6B);
    for (int i = 0; i < 140; i++) applyStimulus(1'b1);
    checkOutput("5n15_len", busy_cnt, 120);

    $display("[TB] 8N2");
    startScenario(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    pushByte(8'h9E);
    for (int i = 0; i < 200; i++) applyStimulus(1'b1);
    checkOutput("8n2_len", busy_cnt, 176);

    $display("[TB] 8 stick parity");
    startScenario(2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
    pushByte(8'h01);
    for (int i = 0; i < 200; i++) applyStimulus(1'b1);
    checkOutput("stick_len", busy_cnt, 176);
    checkBits("stick_bits", 0, 16'h0602, 11);

    $display("[TB] back-to-back frames");
    startScenario(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    pushByte(8'hA5);
    pushByte(8'h00);
    pushByte(8'hFF);
    for (int i = 0; i < 520; i++) applyStimulus(1'b1);
    checkOutput("b2b_pops", pops, 3);
    checkOutput("b2b_len", busy_cnt, 480);
    checkBits("b2b_zero", 160, 16'h0200, 10);

    $display("[TB] reset mid-frame");
    startScenario(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    pushByte(8'h3C);
    for (int i = 0; i < 69; i++) applyStimulus(1'b1);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rstmid_txd", txd, 1'b1);
    checkOutput("rstmid_busy", tx_busy, 1'b0);
    checkOutput("rstmid_rd", fifo_bus.fifo_rd_en, 1'b0);
    active = 1'b0;
    elapsed = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 40; i++) applyStimulus(1'($urandom_range(0, 1)));
    checkOutput("rstmid_pops", pops, 1);

    $display("[TB] break during frame");
    startScenario(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    pushByte(8'hFF);
    pushByte(8'h12);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1);
    break_ctl = 1'b1;
    for (int i = 0; i < 150; i++) applyStimulus(1'b1);
    break_ctl = 1'b0;
    for (int i = 0; i < 170; i++) applyStimulus(1'b1);
    checkOutput("brk_pops", pops, 2);
    checkOutput("brk_len", busy_cnt, 320);

    $display("[TB] random frames");
    startScenario(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
    for (int i = 0; i < 5; i++) pushByte(8'($urandom_range(0, 255)));
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        wls = 2'($urandom_range(0, 3));
        stb = 1'($urandom_range(0, 1));
        pen = 1'($urandom_range(0, 1));
        eps = 1'($urandom_range(0, 1));
        stick_par = 1'($urandom_range(0, 1));
      end
      applyStimulus($urandom_range(0, 2) == 0);
    end
    checkOutput("rand_pops", pops, 5);
    checkOutput("rand_idle", tx_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
